// File: rtl/kem_pkg.sv
// rtl/kem_pkg.sv - command encodings, FSM states and default widths for the KEM load controller
package kem_pkg;

    typedef enum logic [1:0] {
        CMD_IDLE  = 2'd0,
        CMD_LOAD  = 2'd1,
        CMD_START = 2'd2,
        CMD_ABORT = 2'd3
    } kem_cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } kem_state_e;

    localparam int DEF_NCH       = 2;
    localparam int DEF_P_WIDTH   = 16;
    localparam int DEF_Q_DEPTH   = 11;
    localparam int DEF_OUT_WORDS = 8;
    localparam int DEF_OUT_W     = 32;
    localparam int WD_W          = 24;

    // Index width that stays legal (>= 1 bit) for single-entry selections.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/kem_addr_cnt.sv
// rtl/kem_addr_cnt.sv - per-channel write address counter that saturates at the top word and flags overflow
module kem_addr_cnt #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         ovf
);

    // The top address is written once; the flag then blocks further increments.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (inc && !ovf) begin
            if (cnt == {W{1'b1}}) begin
                ovf <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/kem_load_ctrl.sv
// rtl/kem_load_ctrl.sv - loads coefficients into per-channel memories and sequences the KEM core; watchdog under KEM_LOAD_CTRL_TIMEOUT_EN
module kem_load_ctrl
    import kem_pkg::*;
#(
    parameter int NCH       = DEF_NCH,
    parameter int P_WIDTH   = DEF_P_WIDTH,
    parameter int Q_DEPTH   = DEF_Q_DEPTH,
    parameter int OUT_WORDS = DEF_OUT_WORDS,
    parameter int OUT_W     = DEF_OUT_W
) (
    input  logic                           Clk,
    input  logic                           Reset_n,
    input  logic [1:0]                     Cmd,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [idx_w(NCH)-1:0]          in_ch,
    input  logic [P_WIDTH-1:0]             in_data,
    output logic [NCH-1:0]                 mem_wr_en,
    output logic [NCH*Q_DEPTH-1:0]         mem_wr_addr,
    output logic [P_WIDTH-1:0]             mem_wr_di,
    output logic                           core_start,
    output logic                           core_abort,
    input  logic                           core_done,
    input  logic [OUT_WORDS*OUT_W-1:0]     core_res,
    input  logic [idx_w(OUT_WORDS)-1:0]    out_addr,
    output logic [OUT_W-1:0]               out_data,
    output logic                           Valid,
    output logic                           Busy,
    output logic [NCH-1:0]                 Ovf
`ifdef KEM_LOAD_CTRL_TIMEOUT_EN
    ,
    output logic                           Tmo
`endif
);

    kem_state_e         state;
    logic               xfer;
    logic               cnt_clr;
    logic               abort_req;
    logic               tmo_hit;
    logic [NCH-1:0]     ch_sel;
    logic [NCH-1:0]     wr_hit;
    logic [Q_DEPTH-1:0] cnt [NCH];
    logic [OUT_W-1:0]   res_q [OUT_WORDS];

    assign xfer      = in_valid && in_ready;
    assign cnt_clr   = ((state == ST_IDLE) || (state == ST_DONE)) && (Cmd == CMD_LOAD);
    assign abort_req = ((Cmd == CMD_ABORT) && (state != ST_IDLE)) || tmo_hit;

    // Out-of-range channels match no lane and are dropped without a strobe.
    for (genvar g = 0; g < NCH; g++) begin : g_ch
        assign ch_sel[g] = xfer && (int'(in_ch) == g);
        assign wr_hit[g] = ch_sel[g] && !Ovf[g];

        kem_addr_cnt #(.W(Q_DEPTH)) u_cnt (
            .clk    (Clk),
            .resetn (Reset_n),
            .clr    (cnt_clr),
            .inc    (ch_sel[g]),
            .cnt    (cnt[g]),
            .ovf    (Ovf[g])
        );
    end

`ifdef KEM_LOAD_CTRL_TIMEOUT_EN
    localparam logic [WD_W-1:0] WD_LAST = {WD_W{1'b1}} - 1'b1;
    logic [WD_W-1:0] wd_cnt;

    // Fires on the (2**24-1)th consecutive RUN cycle that has no core_done.
    assign tmo_hit = (state == ST_RUN) && !core_done && (wd_cnt == WD_LAST);

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            wd_cnt <= '0;
            Tmo    <= 1'b0;
        end else begin
            wd_cnt <= (state == ST_RUN) ? wd_cnt + 1'b1 : '0;
            if (cnt_clr) begin
                Tmo <= 1'b0;
            end else if (tmo_hit) begin
                Tmo <= 1'b1;
            end
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state       <= ST_IDLE;
            in_ready    <= 1'b0;
            Busy        <= 1'b0;
            Valid       <= 1'b0;
            core_start  <= 1'b0;
            core_abort  <= 1'b0;
            mem_wr_en   <= '0;
            mem_wr_addr <= '0;
            mem_wr_di   <= '0;
            out_data    <= '0;
            for (int w = 0; w < OUT_WORDS; w++) begin
                res_q[w] <= '0;
            end
        end else begin
            core_start <= 1'b0;
            core_abort <= 1'b0;
            mem_wr_en  <= wr_hit;
            if (|wr_hit) begin
                mem_wr_di <= in_data;
            end
            for (int c = 0; c < NCH; c++) begin
                if (wr_hit[c]) begin
                    mem_wr_addr[c*Q_DEPTH +: Q_DEPTH] <= cnt[c];
                end
            end
            out_data <= (int'(out_addr) < OUT_WORDS) ? res_q[out_addr] : '0;

            if (abort_req) begin
                state      <= ST_IDLE;
                core_abort <= 1'b1;
                Valid      <= 1'b0;
                Busy       <= 1'b0;
                in_ready   <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE, ST_DONE: begin
                        if (Cmd == CMD_LOAD) begin
                            state    <= ST_LOAD;
                            Valid    <= 1'b0;
                            in_ready <= 1'b1;
                        end
                    end
                    ST_LOAD: begin
                        if (Cmd == CMD_START) begin
                            state      <= ST_RUN;
                            core_start <= 1'b1;
                            in_ready   <= 1'b0;
                            Busy       <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (core_done) begin
                            state <= ST_DONE;
                            Busy  <= 1'b0;
                            Valid <= 1'b1;
                            for (int w = 0; w < OUT_WORDS; w++) begin
                                res_q[w] <= core_res[w*OUT_W +: OUT_W];
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_kem_load_ctrl.sv
// tb/tb_kem_load_ctrl.sv - randomized bench for kem_load_ctrl against a behavioural reference model
module tb_kem_load_ctrl;

    localparam int NCH   = 2;
    localparam int PW    = 16;
    localparam int QD    = 11;
    localparam int DEPTH = 1 << QD;
    localparam int OW    = 8;
    localparam int OWW   = 32;
    localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_DONE = 3;

    logic              Clk;
    logic              Reset_n;
    logic [1:0]        Cmd;
    logic              in_valid;
    logic              in_ready;
    logic [0:0]        in_ch;
    logic [PW-1:0]     in_data;
    logic [NCH-1:0]    mem_wr_en;
    logic [NCH*QD-1:0] mem_wr_addr;
    logic [PW-1:0]     mem_wr_di;
    logic              core_start;
    logic              core_abort;
    logic              core_done;
    logic [OW*OWW-1:0] core_res;
    logic [2:0]        out_addr;
    logic [OWW-1:0]    out_data;
    logic              Valid;
    logic              Busy;
    logic [NCH-1:0]    Ovf;
`ifdef KEM_LOAD_CTRL_TIMEOUT_EN
    logic              Tmo;
`endif

    kem_load_ctrl dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .Cmd         (Cmd),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_ch       (in_ch),
        .in_data     (in_data),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_di   (mem_wr_di),
        .core_start  (core_start),
        .core_abort  (core_abort),
        .core_done   (core_done),
        .core_res    (core_res),
        .out_addr    (out_addr),
        .out_data    (out_data),
        .Valid       (Valid),
        .Busy        (Busy),
        .Ovf         (Ovf)
`ifdef KEM_LOAD_CTRL_TIMEOUT_EN
        ,
        .Tmo         (Tmo)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: what the controller must remember
    int             m_mode;
    int             m_cnt [NCH];
    logic [NCH-1:0] m_ovf;
    logic           m_valid;
    logic [OWW-1:0] m_res [OW];

    // Expected registered outputs after the coming edge
    logic [NCH-1:0] e_en;
    int             e_addr [NCH];
    logic [PW-1:0]  e_di;
    logic           e_start, e_abort;
    logic [OWW-1:0] e_out;

    // Observed write-port traffic
    int             wr_cnt [NCH];
    int             last_addr [NCH];
    logic [PW-1:0]  last_di [NCH];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int c;
        e_en    = '0;
        e_start = 1'b0;
        e_abort = 1'b0;
        if (!Reset_n) begin
            m_mode  = M_IDLE;
            m_valid = 1'b0;
            m_ovf   = '0;
            for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
            for (int w = 0; w < OW; w++) m_res[w] = '0;
            e_out = '0;
        end else begin
            e_out = (int'(out_addr) < OW) ? m_res[out_addr] : '0;
            if (m_mode == M_LOAD && in_valid && int'(in_ch) < NCH) begin
                c = int'(in_ch);
                if (!m_ovf[c]) begin
                    e_en[c]   = 1'b1;
                    e_addr[c] = m_cnt[c];
                    e_di      = in_data;
                    if (m_cnt[c] == DEPTH - 1) m_ovf[c] = 1'b1;
                    else m_cnt[c] = m_cnt[c] + 1;
                end
            end
            if (Cmd == 2'd3 && m_mode != M_IDLE) begin
                m_mode  = M_IDLE;
                e_abort = 1'b1;
                m_valid = 1'b0;
            end else if ((m_mode == M_IDLE || m_mode == M_DONE) && Cmd == 2'd1) begin
                m_mode  = M_LOAD;
                m_valid = 1'b0;
                m_ovf   = '0;
                for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
            end else if (m_mode == M_LOAD && Cmd == 2'd2) begin
                m_mode  = M_RUN;
                e_start = 1'b1;
            end else if (m_mode == M_RUN && core_done) begin
                m_mode  = M_DONE;
                m_valid = 1'b1;
                for (int w = 0; w < OW; w++) m_res[w] = core_res[w*OWW +: OWW];
            end
        end
    endtask

    task automatic check_all();
        chk("in_ready", in_ready, m_mode == M_LOAD);
        chk("busy", Busy, m_mode == M_RUN);
        chk("valid", Valid, m_valid);
        chk("ovf", Ovf, m_ovf);
        chk("core_start", core_start, e_start);
        chk("core_abort", core_abort, e_abort);
        chk("mem_wr_en", mem_wr_en, e_en);
        chk("out_data", out_data, e_out);
        for (int c = 0; c < NCH; c++) begin
            if (e_en[c]) chk("mem_wr_addr", mem_wr_addr[c*QD +: QD], e_addr[c]);
            if (mem_wr_en[c]) begin
                wr_cnt[c]++;
                last_addr[c] = int'(mem_wr_addr[c*QD +: QD]);
                last_di[c]   = mem_wr_di;
            end
        end
        if (|e_en) chk("mem_wr_di", mem_wr_di, e_di);
    endtask

    task automatic do_cycle();
        model_step();
        @(posedge Clk);
        #1;
        check_all();
    endtask

    task automatic rand_side();
        core_done = ($urandom_range(0, 7) == 0);
        for (int w = 0; w < OW; w++) core_res[w*OWW +: OWW] = $urandom;
        out_addr = 3'($urandom_range(0, 7));
    endtask

    task automatic clear_obs();
        for (int c = 0; c < NCH; c++) begin
            wr_cnt[c]    = 0;
            last_addr[c] = -1;
        end
    endtask

    // n accepted transfers with random gaps; ch < 0 picks a random channel
    task automatic load_n(input int ch, input int n);
        int i;
        i = 0;
        while (i < n) begin
            Cmd      = 2'd0;
            in_valid = ($urandom_range(0, 3) != 0);
            in_ch    = (ch < 0) ? 1'($urandom_range(0, 1)) : 1'(ch);
            in_data  = in_valid ? PW'(i) : PW'($urandom);
            rand_side();
            do_cycle();
            if (in_valid) i++;
        end
        in_valid = 1'b0;
    endtask

    task automatic issue(input logic [1:0] cmd);
        Cmd = cmd;
        do_cycle();
        Cmd = 2'd0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        Reset_n = 1'b0; Cmd = 2'd0; in_valid = 1'b0; in_ch = '0; in_data = '0;
        core_done = 1'b0; core_res = '0; out_addr = '0;
        clear_obs();
        repeat (3) do_cycle();
        chk("reset_valid", Valid, 1'b0);
        chk("reset_busy", Busy, 1'b0);
        chk("reset_in_ready", in_ready, 1'b0);
        chk("reset_out_data", out_data, 32'h0);
        Reset_n = 1'b1;
        do_cycle();

        // Fill ch0 with 1024 words and ch1 up to one short of full
        issue(2'd1);
        chk("load_in_ready", in_ready, 1'b1);
        load_n(0, 1024);
        load_n(1, 2047);
        chk("ch0_writes", wr_cnt[0], 1024);
        chk("ch0_last_addr", last_addr[0], 1023);
        chk("ch0_last_data", last_di[0], 16'd1023);
        chk("ch1_writes", wr_cnt[1], 2047);
        chk("ch1_last_addr", last_addr[1], 2046);
        chk("ovf_none", Ovf, 2'b00);

        // Top word of ch1 is written once, then further writes vanish
        load_n(1, 1);
        chk("ch1_top_addr", last_addr[1], 2047);
        chk("ovf_set", Ovf, 2'b10);
        load_n(1, 1);
        chk("ch1_dropped", wr_cnt[1], 2048);
        chk("ovf_held", Ovf, 2'b10);

        // Start with a coincident transfer, ignored commands in RUN, then completion
        Cmd = 2'd2; in_valid = 1'b1; in_ch = 1'b0; in_data = 16'hABCD; core_done = 1'b0;
        do_cycle();
        in_valid = 1'b0; Cmd = 2'd0;
        chk("start_pulse", core_start, 1'b1);
        chk("start_xfer_data", last_di[0], 16'hABCD);
        chk("run_busy", Busy, 1'b1);
        repeat (20) begin
            Cmd = 2'($urandom_range(0, 2)); in_valid = 1'($urandom_range(0, 1));
            core_done = 1'b0; out_addr = 3'($urandom_range(0, 7));
            do_cycle();
        end
        Cmd = 2'd0; core_done = 1'b1;
        for (int k = 0; k < OW; k++) core_res[k*OWW +: OWW] = 32'h1000_0000 + k;
        do_cycle();
        core_done = 1'b0; out_addr = 3'd5;
        chk("done_valid", Valid, 1'b1);
        do_cycle();
        chk("readout_w5", out_data, 32'h1000_0005);

        // Abort wins over a coincident core_done
        issue(2'd1);
        load_n(-1, 5);
        issue(2'd2);
        repeat (4) do_cycle();
        Cmd = 2'd3; core_done = 1'b1;
        do_cycle();
        Cmd = 2'd0; core_done = 1'b0;
        chk("abort_pulse", core_abort, 1'b1);
        chk("abort_valid", Valid, 1'b0);
        chk("abort_busy", Busy, 1'b0);
        do_cycle();
        chk("abort_single", core_abort, 1'b0);

        // Reset in the middle of a load restarts addressing from zero
        issue(2'd1);
        load_n(-1, 100);
        Reset_n = 1'b0;
        do_cycle();
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_no_abort", core_abort, 1'b0);
        Reset_n = 1'b1;
        issue(2'd1);
        clear_obs();
        load_n(0, 1);
        chk("reload_addr0", last_addr[0], 0);
        load_n(1, 1);
        chk("reload_ch1_addr0", last_addr[1], 0);

        // Free-running random traffic
        repeat (2500) begin
            case ($urandom_range(0, 15))
                10, 11:  Cmd = 2'd1;
                12, 13:  Cmd = 2'd2;
                14:      Cmd = 2'd3;
                default: Cmd = 2'd0;
            endcase
            Reset_n  = ($urandom_range(0, 299) != 0);
            in_valid = 1'($urandom_range(0, 1));
            in_ch    = 1'($urandom_range(0, 1));
            in_data  = PW'($urandom);
            rand_side();
            do_cycle();
        end
        Reset_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
